// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_pkg
// Brief    : Shared types for the UART byte buffer (FSM states, byte type).
// Revision : 1.0 - initial release
// ============================================================================
package uart_fifo_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [0:0] {
        TX_IDLE   = 1'b0,
        TX_STROBE = 1'b1
    } tx_state_t;

endpackage : uart_fifo_pkg
`default_nettype wire

// File: rtl/uart_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock show-ahead byte FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  byte_t                 i_data,
    input  logic                  i_pop,
    output byte_t                 o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    byte_t                 r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Count never exceeds depth, so its MSB alone marks "full".
    assign w_full  = r_count[DEPTH_LOG2];
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Brief    : RX/TX byte FIFOs between CPU registers and the UART core.
//            Define UART_FIFO_OVF_EN to build the sticky TX overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [7:0]            cpu_rx_data,
    output logic                  cpu_rx_valid,
    input  logic                  cpu_rx_rd,
    input  logic [7:0]            cpu_tx_data,
    input  logic                  cpu_tx_wr,
    output logic                  cpu_tx_full,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  ovf,
    input  logic                  ovf_clr,
    input  logic [7:0]            rx_data,
    input  logic                  rx_full,
    output logic                  rd,
    output logic [7:0]            tx_data,
    output logic                  wr,
    input  logic                  tx_ready
);

    rx_state_t r_rx_state, w_rx_state_nxt;
    tx_state_t r_tx_state, w_tx_state_nxt;
    logic      r_rd, w_rd_nxt;
    logic      r_wr, w_wr_nxt;
    byte_t     r_tx_data;
    logic      w_rx_push;
    logic      w_rx_fifo_full;
    logic      w_rx_fifo_empty;
    logic      w_tx_pop;
    logic      w_tx_fifo_empty;
    byte_t     w_tx_head;

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_data  (rx_data),
        .i_pop   (cpu_rx_rd),
        .o_data  (cpu_rx_data),
        .o_full  (w_rx_fifo_full),
        .o_empty (w_rx_fifo_empty),
        .o_count (rx_count)
    );

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cpu_tx_wr),
        .i_data  (cpu_tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (cpu_tx_full),
        .o_empty (w_tx_fifo_empty),
        .o_count (tx_count)
    );

    // RX drain: the ACK state keeps rd low for a cycle while the core clears rx_full.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rd_nxt       = 1'b0;
        w_rx_push      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (rx_full && !w_rx_fifo_full) begin
                    w_rx_push      = 1'b1;
                    w_rd_nxt       = 1'b1;
                    w_rx_state_nxt = RX_ACK;
                end
            end
            RX_ACK:  w_rx_state_nxt = RX_IDLE;
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_wr_nxt       = 1'b0;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_fifo_empty && tx_ready) begin
                    w_tx_pop       = 1'b1;
                    w_wr_nxt       = 1'b1;
                    w_tx_state_nxt = TX_STROBE;
                end
            end
            TX_STROBE: w_tx_state_nxt = TX_IDLE;
            default:   w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_tx_state <= TX_IDLE;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_tx_state <= w_tx_state_nxt;
            r_rd       <= w_rd_nxt;
            r_wr       <= w_wr_nxt;
            if (w_tx_pop) r_tx_data <= w_tx_head;
        end
    end

`ifdef UART_FIFO_OVF_EN
    logic r_ovf;

    // Set has priority so a rejected write coinciding with a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (cpu_tx_wr && cpu_tx_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = ovf_clr & 1'b0;
`endif

    assign cpu_rx_valid = ~w_rx_fifo_empty;
    assign rd           = r_rd;
    assign wr           = r_wr;
    assign tx_data      = r_tx_data;

endmodule : uart_fifo
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo
// Brief    : Self-checking bench for uart_fifo (queue-based reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;

    localparam int DL = 4;
    localparam int D  = 1 << DL;
`ifdef UART_FIFO_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    cpu_rx_data;
    logic          cpu_rx_valid;
    logic          cpu_rx_rd;
    logic [7:0]    cpu_tx_data;
    logic          cpu_tx_wr;
    logic          cpu_tx_full;
    logic [DL:0]   rx_count;
    logic [DL:0]   tx_count;
    logic          ovf;
    logic          ovf_clr;
    logic [7:0]    rx_data;
    logic          rx_full;
    logic          rd;
    logic [7:0]    tx_data;
    logic          wr;
    logic          tx_ready;

    uart_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_rx_data  (cpu_rx_data),
        .cpu_rx_valid (cpu_rx_valid),
        .cpu_rx_rd    (cpu_rx_rd),
        .cpu_tx_data  (cpu_tx_data),
        .cpu_tx_wr    (cpu_tx_wr),
        .cpu_tx_full  (cpu_tx_full),
        .rx_count     (rx_count),
        .tx_count     (tx_count),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr),
        .rx_data      (rx_data),
        .rx_full      (rx_full),
        .rd           (rd),
        .tx_data      (tx_data),
        .wr           (wr),
        .tx_ready     (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] strobes[$];
    bit         m_rd, m_wr, m_ovf;
    logic [7:0] m_txd;
    int         tx_hold, tx_gap;

    typedef struct {
        bit         wr;
        logic [7:0] data;
        bit         clr;
        int         exp_cnt;
        bit         exp_full;
        bit         exp_ovf;
    } vec_t;
    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rd = 0; m_wr = 0; m_ovf = 0; m_txd = 8'h00;
    endtask

    task automatic check_all();
        chk("rx_count", 32'(rx_count), 32'(rxq.size()));
        chk("tx_count", 32'(tx_count), 32'(txq.size()));
        chk("cpu_rx_valid", 32'(cpu_rx_valid), 32'(rxq.size() > 0));
        if (rxq.size() > 0) chk("cpu_rx_data", 32'(cpu_rx_data), 32'(rxq[0]));
        chk("cpu_tx_full", 32'(cpu_tx_full), 32'(txq.size() == D));
        chk("rd", 32'(rd), 32'(m_rd));
        chk("wr", 32'(wr), 32'(m_wr));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // One clock: advance the model from pre-edge inputs, clock the DUT, play the core, check.
    task automatic cycle();
        bit rxp, rxo, txp, txo, pre_rd, pre_wr;
        rxp = rx_full && !m_rd && (rxq.size() < D);
        rxo = cpu_rx_rd && (rxq.size() > 0);
        txp = cpu_tx_wr && (txq.size() < D);
        txo = !m_wr && tx_ready && (txq.size() > 0);
        if (OVF_ON) begin
            if (cpu_tx_wr && txq.size() == D) m_ovf = 1;
            else if (ovf_clr)                 m_ovf = 0;
        end
        if (txo) m_txd = txq.pop_front();
        if (rxo) void'(rxq.pop_front());
        if (rxp) rxq.push_back(rx_data);
        if (txp) txq.push_back(cpu_tx_data);
        m_rd = rxp;
        m_wr = txo;
        pre_rd = rd;
        pre_wr = wr;
        @(posedge clk);
        #1;
        if (pre_rd) rx_full = 1'b0;
        if (pre_wr) begin
            tx_ready = 1'b0;
            tx_hold  = tx_gap;
        end else if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) tx_ready = 1'b1;
        end
        if (wr === 1'b1) strobes.push_back(tx_data);
        check_all();
    endtask

    task automatic core_send(input logic [7:0] b);
        rx_data = b;
        rx_full = 1'b1;
        for (int k = 0; k < 10 && rx_full; k++) cycle();
        chk("core_send_timeout", 32'(rx_full), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_b;
        bit         seen;
        int         pop_pct, wr_pct, gap_max;

        rst_n = 0; cpu_rx_rd = 0; cpu_tx_data = 0; cpu_tx_wr = 0; ovf_clr = 0;
        rx_data = 0; rx_full = 0; tx_ready = 1; tx_hold = 0; tx_gap = 20;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1;
        cycle();

        // Single RX byte through the drain FSM
        rx_data = 8'h45; rx_full = 1'b1;
        cycle();
        chk("rx45_rd", 32'(rd), 32'd1);
        chk("rx45_valid", 32'(cpu_rx_valid), 32'd1);
        chk("rx45_data", 32'(cpu_rx_data), 32'h45);
        chk("rx45_count", 32'(rx_count), 32'd1);
        cycle();
        chk("rx45_rd_one_cycle", 32'(rd), 32'd0);
        cpu_rx_rd = 1; cycle(); cpu_rx_rd = 0;
        chk("rx45_popped", 32'(rx_count), 32'd0);

        // Three TX bytes with a slow transmitter
        strobes.delete();
        tx_gap = 20;
        cpu_tx_wr = 1;
        cpu_tx_data = 8'h49; cycle();
        cpu_tx_data = 8'h4A; cycle();
        cpu_tx_data = 8'h4B; cycle();
        cpu_tx_wr = 0;
        for (int k = 0; k < 120 && !(strobes.size() == 3 && tx_count == 0 && tx_ready); k++) cycle();
        chk("tx3_strobes", 32'(strobes.size()), 32'd3);
        if (strobes.size() == 3) begin
            chk("tx3_b0", 32'(strobes[0]), 32'h49);
            chk("tx3_b1", 32'(strobes[1]), 32'h4A);
            chk("tx3_b2", 32'(strobes[2]), 32'h4B);
        end
        chk("tx3_count", 32'(tx_count), 32'd0);

        // RX full back-pressure with a 17th byte waiting in the core
        for (int i = 0; i < D; i++) core_send(8'h60 + 8'(i));
        chk("rxfill_count", 32'(rx_count), 32'(D));
        rx_data = 8'hAA; rx_full = 1'b1;
        repeat (5) begin
            cycle();
            chk("rxfill_rd_held", 32'(rd), 32'd0);
        end
        chk("rxfill_count_held", 32'(rx_count), 32'(D));
        cpu_rx_rd = 1; cycle(); cpu_rx_rd = 0;
        seen = 0;
        repeat (2) begin
            cycle();
            if (rd) seen = 1;
        end
        chk("rxfill_aa_drained", 32'(seen), 32'd1);
        for (int j = 0; j < D; j++) begin
            exp_b = (j == D - 1) ? 8'hAA : 8'h61 + 8'(j);
            chk("rxfill_order", 32'(cpu_rx_data), 32'(exp_b));
            cpu_rx_rd = 1; cycle();
        end
        cpu_rx_rd = 0;
        chk("rxfill_empty", 32'(rx_count), 32'd0);

        // Simultaneous push and pop on a FIFO holding 3 bytes
        core_send(8'h31); core_send(8'h32); core_send(8'h33);
        rx_data = 8'h34; rx_full = 1'b1; cpu_rx_rd = 1;
        cycle();
        cpu_rx_rd = 0;
        chk("simul_count", 32'(rx_count), 32'd3);
        chk("simul_rd", 32'(rd), 32'd1);
        cycle();
        for (int j = 0; j < 3; j++) begin
            chk("simul_order", 32'(cpu_rx_data), 32'h32 + 32'(j));
            cpu_rx_rd = 1; cycle();
        end
        cpu_rx_rd = 1; cycle(); cpu_rx_rd = 0;
        chk("pop_empty_count", 32'(rx_count), 32'd0);
        chk("pop_empty_valid", 32'(cpu_rx_valid), 32'd0);

        // Table: TX fill with the transmitter stalled, then overflow/clear behaviour
        for (int i = 0; i < D; i++)
            vecs[i] = '{wr: 1, data: 8'h10 + 8'(i), clr: 0, exp_cnt: i + 1, exp_full: (i == D - 1), exp_ovf: 0};
        vecs[D]     = '{wr: 1, data: 8'h99, clr: 0, exp_cnt: D, exp_full: 1, exp_ovf: OVF_ON};
        vecs[D + 1] = '{wr: 0, data: 8'h00, clr: 1, exp_cnt: D, exp_full: 1, exp_ovf: 0};
        vecs[D + 2] = '{wr: 1, data: 8'h99, clr: 1, exp_cnt: D, exp_full: 1, exp_ovf: OVF_ON};
        vecs[D + 3] = '{wr: 0, data: 8'h00, clr: 1, exp_cnt: D, exp_full: 1, exp_ovf: 0};
        tx_ready = 0; tx_hold = 0;
        for (int i = 0; i < D + 4; i++) begin
            cpu_tx_wr = vecs[i].wr; cpu_tx_data = vecs[i].data; ovf_clr = vecs[i].clr;
            cycle();
            chk("tbl_tx_count", 32'(tx_count), 32'(vecs[i].exp_cnt));
            chk("tbl_tx_full", 32'(cpu_tx_full), 32'(vecs[i].exp_full));
            chk("tbl_ovf", 32'(ovf), 32'(vecs[i].exp_ovf));
        end
        cpu_tx_wr = 0; ovf_clr = 0;

        // Asynchronous reset while a strobe is on the wire
        tx_ready = 1; tx_gap = 20;
        cycle();
        chk("rst_mid_wr_before", 32'(wr), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_wr", 32'(wr), 32'd0);
        chk("rst_mid_rd", 32'(rd), 32'd0);
        chk("rst_mid_tx_count", 32'(tx_count), 32'd0);
        chk("rst_mid_tx_full", 32'(cpu_tx_full), 32'd0);
        model_reset();
        tx_hold = 0; tx_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check_all();
        strobes.delete();
        repeat (30) cycle();
        chk("rst_no_strobe", 32'(strobes.size()), 32'd0);

        // Randomized traffic in two load profiles
        for (int ph = 0; ph < 2; ph++) begin
            pop_pct = (ph == 0) ? 10 : 60;
            wr_pct  = (ph == 0) ? 70 : 30;
            gap_max = (ph == 0) ? 8 : 2;
            for (int n = 0; n < 1500; n++) begin
                cpu_rx_rd   = ($urandom_range(0, 99) < pop_pct);
                cpu_tx_wr   = ($urandom_range(0, 99) < wr_pct);
                cpu_tx_data = 8'($urandom);
                ovf_clr     = ($urandom_range(0, 9) == 0);
                if (!rx_full && $urandom_range(0, 2) == 0) begin
                    rx_full = 1'b1;
                    rx_data = 8'($urandom);
                end
                tx_gap = $urandom_range(1, gap_max);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_uart_fifo
`default_nettype wire
